// File: rtl/scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer_if
// Description : Signal bundle between a scan controller and the 2-to-4 digit
//               decoder sequencer.
//               run      - free-running scan enable (level)
//               step     - manual single-digit advance (edge detected in DUT)
//               div_sel  - dwell select, DWELL = 4 << div_sel clocks
//               dec_a    - decoder select MSB
//               dec_b    - decoder select LSB
//               dec_en_n - decoder enable, active-low
//               frame    - one-clock pulse on select wrap 3->0
//               busy     - sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface scan_sequencer_if;

    logic       run;
    logic       step;
    logic [1:0] div_sel;
    logic       dec_a;
    logic       dec_b;
    logic       dec_en_n;
    logic       frame;
    logic       busy;

    // Controller side: drives the controls, observes the decoder drive.
    modport master (
        output run,
        output step,
        output div_sel,
        input  dec_a,
        input  dec_b,
        input  dec_en_n,
        input  frame,
        input  busy
    );

    // Sequencer side.
    modport slave (
        input  run,
        input  step,
        input  div_sel,
        output dec_a,
        output dec_b,
        output dec_en_n,
        output frame,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer
// Description : Multiplexed-display digit scanner driving a 2-to-4 decoder
//               with active-low enable. Each digit is shown for DWELL clocks
//               and separated by BLANK_CYCLES clocks of blanking, during
//               which the select lines are updated so the decoder never
//               glitches onto a wrong digit while enabled.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               sif  - scan_sequencer_if.slave (run, step, div_sel in;
//                      dec_a, dec_b, dec_en_n, frame, busy out)
// Parameters  : BLANK_CYCLES - blanking clocks between digits, 2..15
// Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer #(
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    scan_sequencer_if.slave  sif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_blank = 2'd1;
    localparam logic [1:0] c_st_drive = 2'd2;

    // Last value of the blanking counter before moving to DRIVE.
    localparam logic [3:0] c_blank_last = 4'(BLANK_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nx;
    logic [3:0] r_blank_cnt;
    logic [3:0] w_blank_cnt_nx;
    logic [4:0] r_dwell_cnt;
    logic [4:0] w_dwell_cnt_nx;
    logic [4:0] r_dwell_last;      // dwell length - 1, latched on DRIVE entry
    logic [4:0] w_dwell_last_nx;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nx;
    logic       r_one_shot;        // current visit was started by a step edge
    logic       w_one_shot_nx;
    logic       r_adv_pending;     // a digit finished; select must move on
    logic       w_adv_pending_nx;
    logic       r_frame;
    logic       w_frame_nx;
    logic       r_step_q;
    logic       r_dec_en_n;
    logic       r_busy;

    logic       w_step_edge;
    logic       w_abort;
    logic       w_advance;
    logic [4:0] w_dwell_sel;

    // ------------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------------
    assign w_step_edge = sif.step & ~r_step_q;

    // Dropping run stops a free-running scan at once; a step-initiated
    // visit ignores run and always completes its single digit.
    assign w_abort = ~sif.run & ~r_one_shot;

    always_comb begin
        w_dwell_sel = 5'd3;
        case (sif.div_sel)
            2'd0:    w_dwell_sel = 5'd3;
            2'd1:    w_dwell_sel = 5'd7;
            2'd2:    w_dwell_sel = 5'd15;
            2'd3:    w_dwell_sel = 5'd31;
            default: w_dwell_sel = 5'd3;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx       = r_state;
        w_blank_cnt_nx   = r_blank_cnt;
        w_dwell_cnt_nx   = r_dwell_cnt;
        w_dwell_last_nx  = r_dwell_last;
        w_sel_nx         = r_sel;
        w_one_shot_nx    = r_one_shot;
        w_adv_pending_nx = r_adv_pending;
        w_frame_nx       = 1'b0;
        w_advance        = 1'b0;

        case (r_state)
            c_st_idle: begin
                // Decoder is already disabled here, so a pending advance
                // can be applied straight away.
                w_advance = r_adv_pending;
                if (sif.run) begin
                    // run wins over a coincident step edge: no one-shot.
                    w_state_nx     = c_st_blank;
                    w_blank_cnt_nx = 4'd0;
                end else if (w_step_edge) begin
                    w_state_nx     = c_st_blank;
                    w_blank_cnt_nx = 4'd0;
                    w_one_shot_nx  = 1'b1;
                end
            end

            c_st_blank: begin
                if (w_abort) begin
                    w_state_nx       = c_st_idle;
                    w_blank_cnt_nx   = 4'd0;
                    w_adv_pending_nx = 1'b0;
                end else begin
                    // Select moves only at the end of the first blank clock,
                    // so dec_en_n has been high for a full cycle beforehand.
                    w_advance = r_adv_pending && (r_blank_cnt == 4'd0);
                    if (r_blank_cnt == c_blank_last) begin
                        w_state_nx      = c_st_drive;
                        w_blank_cnt_nx  = 4'd0;
                        w_dwell_cnt_nx  = 5'd0;
                        w_dwell_last_nx = w_dwell_sel;
                    end else begin
                        w_blank_cnt_nx = r_blank_cnt + 4'd1;
                    end
                end
            end

            c_st_drive: begin
                if (w_abort) begin
                    w_state_nx     = c_st_idle;
                    w_dwell_cnt_nx = 5'd0;
                end else if (r_dwell_cnt == r_dwell_last) begin
                    w_dwell_cnt_nx   = 5'd0;
                    w_adv_pending_nx = 1'b1;
                    if (sif.run && !r_one_shot) begin
                        w_state_nx     = c_st_blank;
                        w_blank_cnt_nx = 4'd0;
                    end else begin
                        w_state_nx    = c_st_idle;
                        w_one_shot_nx = 1'b0;
                    end
                end else begin
                    w_dwell_cnt_nx = r_dwell_cnt + 5'd1;
                end
            end

            default: begin
                w_state_nx     = c_st_idle;
                w_blank_cnt_nx = 4'd0;
                w_dwell_cnt_nx = 5'd0;
                w_one_shot_nx  = 1'b0;
            end
        endcase

        if (w_advance) begin
            w_sel_nx         = r_sel + 2'd1;
            w_frame_nx       = (r_sel == 2'd3);
            w_adv_pending_nx = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers. dec_en_n and busy are registered from the
    // next state so they line up exactly with the state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_blank_cnt   <= 4'd0;
            r_dwell_cnt   <= 5'd0;
            r_dwell_last  <= 5'd0;
            r_sel         <= 2'd0;
            r_one_shot    <= 1'b0;
            r_adv_pending <= 1'b0;
            r_frame       <= 1'b0;
            r_step_q      <= 1'b0;
            r_dec_en_n    <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_blank_cnt   <= w_blank_cnt_nx;
            r_dwell_cnt   <= w_dwell_cnt_nx;
            r_dwell_last  <= w_dwell_last_nx;
            r_sel         <= w_sel_nx;
            r_one_shot    <= w_one_shot_nx;
            r_adv_pending <= w_adv_pending_nx;
            r_frame       <= w_frame_nx;
            r_step_q      <= sif.step;
            r_dec_en_n    <= (w_state_nx != c_st_drive);
            r_busy        <= (w_state_nx != c_st_idle);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sif.dec_a    = r_sel[1];
    assign sif.dec_b    = r_sel[0];
    assign sif.dec_en_n = r_dec_en_n;
    assign sif.frame    = r_frame;
    assign sif.busy     = r_busy;

endmodule
`default_nettype wire

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter: BLANK_CYCLES, 2, blanking interval in clocks between digits; legal range 2..15.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: run  input  1  free-running scan enable, level-sensitive.
REQ-006 SHALL have port: step  input  1  manual single-digit advance; rising edge detected internally.
REQ-007 SHALL have port: div_sel  input  2  dwell select; DWELL = 4 << div_sel clocks (4, 8, 16, 32).
REQ-008 SHALL have port: dec_a  output  1  decoder input A (select MSB).
REQ-009 SHALL have port: dec_b  output  1  decoder input B (select LSB).
REQ-010 SHALL have port: dec_en_n  output  1  decoder enable E, active-low; 1 = all decoder outputs inactive.
REQ-011 SHALL have port: frame  output  1  one-clock pulse on select wrap 3->0.
REQ-012 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL hold a 2-bit select sel, with dec_a = sel[1] and dec_b = sel[0]; digit index = {dec_a, dec_b}.
REQ-014 SHALL drive all outputs from flops, with no combinational path from any input to any output.
REQ-015 SHALL implement three states: IDLE, BLANK and DRIVE; dec_en_n = 0 only in DRIVE.
REQ-016 IDLE -> BLANK SHALL occur when run = 1, or when a step rising edge is detected while run = 0; the step case sets a one-shot flag.
REQ-017 BLANK SHALL last exactly BLANK_CYCLES clocks, then go to DRIVE.
REQ-018 DRIVE SHALL last exactly DWELL clocks, with div_sel sampled on DRIVE entry; changes to div_sel mid-dwell SHALL have no effect until the next DRIVE.
REQ-019 At DRIVE end, the FSM SHALL go to BLANK if run = 1 and no one-shot flag is set, else go to IDLE with the one-shot flag cleared; both cases set advance_pending.
REQ-020 sel SHALL increment mod 4 only on the clock ending the first BLANK cycle, and only when advance_pending is set; this clears advance_pending, guaranteeing dec_en_n was already 1 for one full cycle before A/B change.
REQ-021 In IDLE with advance_pending set, sel SHALL increment on the next clock (dec_en_n already 1) and clear advance_pending.
REQ-022 The initial BLANK after leaving IDLE with advance_pending clear SHALL NOT change sel.
REQ-023 frame SHALL pulse high for one clock coincident with the sel update 3->0; otherwise frame SHALL be 0.
REQ-024 run deasserted in BLANK or DRIVE with no one-shot flag SHALL force IDLE on the next clock: dec_en_n = 1, sel held, no advance, dwell/blank counters cleared.
REQ-025 A step edge while run = 1 or while busy = 1 SHALL be ignored, not queued.
REQ-026 run and a step edge in the same IDLE cycle SHALL be treated as run only, with no one-shot flag set.
REQ-027 The step edge detector SHALL register step; an edge is step = 1 with the previous sample = 0; holding step high SHALL produce one advance only.

Reset
REQ-028 While rst = 1 the block SHALL be in IDLE, with sel = 0, dec_a = 0, dec_b = 0, dec_en_n = 1, frame = 0, busy = 0, counters = 0, one-shot flag and advance_pending cleared, and step history = 0.
REQ-029 Reset assertion mid-DRIVE SHALL raise dec_en_n asynchronously without waiting for clk.
REQ-030 After rst deasserts, the first state change SHALL occur on a clk edge, never on the rst edge.

Verification
REQ-031 Free-run: BLANK_CYCLES = 2, div_sel = 0, run = 1 from reset -> dec_en_n pattern 1,1,0,0,0,0 repeating every 6 clocks; sel sequence 0,1,2,3,0; frame high for 1 clock every 24 clocks.
REQ-032 Dwell select: div_sel = 3 -> dec_en_n low for exactly 32 consecutive clocks per digit; changing div_sel to 0 mid-dwell -> current dwell stays 32, next dwell is 4.
REQ-033 Single step: run = 0, step held high 10 clocks -> exactly one DRIVE of DWELL clocks on sel = 0, then IDLE with sel = 1; a second step edge -> DRIVE on sel = 1.
REQ-034 Abort: run dropped in the 2nd DRIVE clock on sel = 2 -> dec_en_n = 1 next clock, sel stays 2, busy = 0; run re-asserted -> BLANK, then DRIVE on sel = 2.
REQ-035 Glitch check: across all free-run cycles, dec_a/dec_b never change in a cycle where dec_en_n = 0 or in the cycle dec_en_n rises.
REQ-036 Async reset: rst pulsed mid-DRIVE between clk edges -> dec_en_n = 1 immediately, sel = 0, frame = 0, busy = 0.
